// File: rtl/cam_lvds_align_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_lvds_align_pkg
// Description : Shared state encodings and default constants for the camera
//               LVDS word-alignment controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_lvds_align_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        TRAIN     = 3'd2,
        DONE      = 3'd3,
        FAIL      = 3'd4
    } top_state_t;

    typedef enum logic [2:0] {
        L_IDLE   = 3'd0,
        L_CHECK  = 3'd1,
        L_SLIP   = 3'd2,
        L_SETTLE = 3'd3,
        L_DONE   = 3'd4,
        L_FAIL   = 3'd5
    } lane_state_t;

    localparam logic [7:0] DEF_TRAIN_WORD    = 8'h3A;
    localparam int         DEF_MATCH_CYCLES  = 16;
    localparam int         DEF_SETTLE_CYCLES = 4;
    localparam int         DEF_LOCK_WAIT     = 64;

endpackage
`default_nettype wire

// File: rtl/cam_lvds_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : cam_lvds_lane_align
// Description : Single-lane bitslip trainer: slips until TRAIN_WORD is seen
//               for MATCH_CYCLES consecutive words or W-1 slips are spent.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_lvds_lane_align
    import cam_lvds_align_pkg::*;
#(
    parameter int           W             = 8,
    parameter logic [W-1:0] TRAIN_WORD    = DEF_TRAIN_WORD,
    parameter int           MATCH_CYCLES  = DEF_MATCH_CYCLES,
    parameter int           SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int           SW            = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          go,
    input  logic [W-1:0]  word,
    output logic          bitslip,
    output logic          done,
    output logic          fail,
    output logic [SW-1:0] slips
);

    localparam int          MW          = $clog2(MATCH_CYCLES) + 1;
    localparam int          STW         = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [MW-1:0]  c_match_last  = MW'(MATCH_CYCLES - 1);
    localparam logic [STW-1:0] c_settle_last = STW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0]  c_slip_last   = SW'(W - 1);

    lane_state_t    r_state, w_state_nxt;
    logic [MW-1:0]  r_match, w_match_nxt;
    logic [STW-1:0] r_settle, w_settle_nxt;
    logic [SW-1:0]  r_slips, w_slips_nxt;
    logic           r_bitslip;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= L_IDLE;
            r_match   <= '0;
            r_settle  <= '0;
            r_slips   <= '0;
            r_bitslip <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_match   <= w_match_nxt;
            r_settle  <= w_settle_nxt;
            r_slips   <= w_slips_nxt;
            // The pulse is high exactly while the lane sits in L_SLIP
            r_bitslip <= (w_state_nxt == L_SLIP);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_match_nxt  = r_match;
        w_settle_nxt = r_settle;
        w_slips_nxt  = r_slips;
        if (clear) begin
            w_state_nxt  = L_IDLE;
            w_match_nxt  = '0;
            w_settle_nxt = '0;
            w_slips_nxt  = '0;
        end else begin
            case (r_state)
                L_IDLE: begin
                    if (go) begin
                        w_state_nxt = L_CHECK;
                        w_match_nxt = '0;
                        w_slips_nxt = '0;
                    end
                end
                L_CHECK: begin
                    if (word == TRAIN_WORD) begin
                        w_match_nxt = r_match + 1'b1;
                        if (r_match == c_match_last) begin
                            w_state_nxt = L_DONE;
                        end
                    end else if (r_slips == c_slip_last) begin
                        w_state_nxt = L_FAIL;
                    end else begin
                        w_state_nxt = L_SLIP;
                        w_match_nxt = '0;
                    end
                end
                L_SLIP: begin
                    w_state_nxt  = L_SETTLE;
                    w_slips_nxt  = r_slips + 1'b1;
                    w_settle_nxt = '0;
                end
                L_SETTLE: begin
                    if (r_settle == c_settle_last) begin
                        w_state_nxt = L_CHECK;
                        w_match_nxt = '0;
                    end else begin
                        w_settle_nxt = r_settle + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bitslip = r_bitslip;
    assign done    = (r_state == L_DONE);
    assign fail    = (r_state == L_FAIL);
    assign slips   = r_slips;

endmodule
`default_nettype wire

// File: rtl/cam_lvds_align.sv
`default_nettype none
// ============================================================================
// Module      : cam_lvds_align
// Description : Per-camera LVDS word-alignment controller. Optional macro
//               CAM_LVDS_ALIGN_SLIP_COUNT_EN exposes per-lane slip counts.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_lvds_align
    import cam_lvds_align_pkg::*;
#(
    parameter int           LANES         = 5,
    parameter int           W             = 8,
    parameter logic [W-1:0] TRAIN_WORD    = DEF_TRAIN_WORD,
    parameter int           MATCH_CYCLES  = DEF_MATCH_CYCLES,
    parameter int           SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int           LOCK_WAIT     = DEF_LOCK_WAIT
) (
    input  logic               rxc,
    input  logic               rst,
    input  logic               start,
    input  logic               rx_locked,
    input  logic [LANES*W-1:0] rxd,
    output logic [LANES-1:0]   bitslip,
    output logic               busy,
    output logic               aligned,
    output logic               fail,
    output logic [LANES-1:0]   lane_aligned,
    output logic [LANES-1:0]   lane_fail,
    output logic [LANES*4-1:0] slip_count
);

    localparam int            SW          = $clog2(W);
    localparam int            LW          = $clog2(LOCK_WAIT + 1);
    localparam logic [LW-1:0] c_lock_last = LW'(LOCK_WAIT - 1);

    top_state_t    r_state, w_state_nxt;
    logic [LW-1:0] r_lock_cnt, w_lock_nxt;
    logic          r_busy, r_aligned, r_fail;
    logic          w_lane_clear, w_lane_go;
    logic          w_all_end, w_all_done;
    logic [SW-1:0] w_slips [LANES];

    assign w_all_end  = &(lane_aligned | lane_fail);
    assign w_all_done = &lane_aligned;

    always_ff @(posedge rxc) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
            r_busy     <= 1'b0;
            r_aligned  <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_nxt;
            r_busy     <= (w_state_nxt == WAIT_LOCK) || (w_state_nxt == TRAIN);
            r_aligned  <= (w_state_nxt == DONE);
            r_fail     <= (w_state_nxt == FAIL);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_lock_nxt   = r_lock_cnt;
        w_lane_clear = 1'b0;
        w_lane_go    = 1'b0;
        case (r_state)
            IDLE, FAIL: begin
                if (start) begin
                    w_state_nxt  = WAIT_LOCK;
                    w_lock_nxt   = '0;
                    w_lane_clear = 1'b1;
                end
            end
            DONE: begin
                // Losing lock after alignment forces an automatic retrain
                if (start || !rx_locked) begin
                    w_state_nxt  = WAIT_LOCK;
                    w_lock_nxt   = '0;
                    w_lane_clear = 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (!rx_locked) begin
                    w_lock_nxt = '0;
                end else if (r_lock_cnt == c_lock_last) begin
                    w_state_nxt = TRAIN;
                    w_lock_nxt  = '0;
                    w_lane_go   = 1'b1;
                end else begin
                    w_lock_nxt = r_lock_cnt + 1'b1;
                end
            end
            TRAIN: begin
                if (!rx_locked) begin
                    w_state_nxt  = WAIT_LOCK;
                    w_lock_nxt   = '0;
                    w_lane_clear = 1'b1;
                end else if (w_all_end) begin
                    w_state_nxt = w_all_done ? DONE : FAIL;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy    = r_busy;
    assign aligned = r_aligned;
    assign fail    = r_fail;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cam_lvds_lane_align #(
            .W             (W),
            .TRAIN_WORD    (TRAIN_WORD),
            .MATCH_CYCLES  (MATCH_CYCLES),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .SW            (SW)
        ) u_lane (
            .clk     (rxc),
            .rst     (rst),
            .clear   (w_lane_clear),
            .go      (w_lane_go),
            .word    (rxd[i*W +: W]),
            .bitslip (bitslip[i]),
            .done    (lane_aligned[i]),
            .fail    (lane_fail[i]),
            .slips   (w_slips[i])
        );
`ifdef CAM_LVDS_ALIGN_SLIP_COUNT_EN
        assign slip_count[i*4 +: 4] = 4'(w_slips[i]);
`else
        logic w_slips_unused;
        assign w_slips_unused       = ^w_slips[i];
        assign slip_count[i*4 +: 4] = 4'd0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_lvds_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_lvds_align
// Description : Directed self-checking bench for cam_lvds_align with a
//               rotating-word lane model driven by the bitslip pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_lvds_align;

    localparam int         LANES = 5;
    localparam int         W     = 8;
    localparam logic [7:0] TW    = 8'h3A;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               rx_locked;
    logic [LANES*W-1:0] rxd;
    logic [LANES-1:0]   bitslip;
    logic               busy;
    logic               aligned;
    logic               fail;
    logic [LANES-1:0]   lane_aligned;
    logic [LANES-1:0]   lane_fail;
    logic [LANES*4-1:0] slip_count;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int k          [LANES];
    bit fixed_en   [LANES];
    int pulses     [LANES];
    int snap       [LANES];
    bit prev_bs    [LANES];
    int last_pulse [LANES];
    int bad_width  = 0;
    int bad_space  = 0;
    int n;

    cam_lvds_align dut (
        .rxc          (clk),
        .rst          (rst),
        .start        (start),
        .rx_locked    (rx_locked),
        .rxd          (rxd),
        .bitslip      (bitslip),
        .busy         (busy),
        .aligned      (aligned),
        .fail         (fail),
        .lane_aligned (lane_aligned),
        .lane_fail    (lane_fail),
        .slip_count   (slip_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rot(input logic [7:0] x, input int s);
        return 8'((x << s) | (x >> (8 - s)));
    endfunction

    task automatic drive_rxd();
        for (int i = 0; i < LANES; i++) begin
            rxd[i*W +: W] = fixed_en[i] ? 8'h00 : rot(TW, k[i]);
        end
    endtask

    // Advance one clock; bitslip pulses rotate the modelled lane stream back
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < LANES; i++) begin
            if (bitslip[i]) begin
                pulses[i]++;
                if (prev_bs[i]) bad_width++;
                if ((cyc - last_pulse[i]) < 20 && (cyc - last_pulse[i]) != 6) bad_space++;
                last_pulse[i] = cyc;
                k[i] = (k[i] + 7) % 8;
            end
            prev_bs[i] = bitslip[i];
        end
        drive_rxd();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic take_snap();
        for (int i = 0; i < LANES; i++) snap[i] = pulses[i];
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rx_locked = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            k[i] = 0; fixed_en[i] = 1'b0; pulses[i] = 0;
            prev_bs[i] = 1'b0; last_pulse[i] = -1000;
        end
        drive_rxd();
        repeat (3) step();

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_aligned", 64'(aligned), 64'd0);
        chk("rst_fail", 64'(fail), 64'd0);
        chk("rst_bitslip", 64'(bitslip), 64'd0);
        chk("rst_lanes", 64'({lane_aligned, lane_fail}), 64'd0);
        chk("rst_slipcnt", 64'(slip_count), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_busy", 64'(busy), 64'd0);

        // All lanes already aligned: latency and no slips
        take_snap();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        chk("t1_busy", 64'(busy), 64'd1);
        while (!(aligned || fail) && n < 400) begin step(); n++; end
        chk("t1_latency", 64'(n), 64'd82);
        chk("t1_aligned", 64'({aligned, fail}), 64'b10);
        chk("t1_lane_aligned", 64'(lane_aligned), 64'h1F);
        chk("t1_pulses", 64'(pulses[0]+pulses[1]+pulses[2]+pulses[3]+pulses[4]), 64'd0);

        // Lane 2 off by 3, sync lane off by 5; a start while busy is ignored
        k[2] = 3; k[4] = 5;
        drive_rxd();
        take_snap();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        chk("t2_aligned_drop", 64'(aligned), 64'd0);
        while (!(aligned || fail) && n < 400) begin
            start = (n == 70);
            step();
            n++;
        end
        start = 1'b0;
        chk("t2_latency", 64'(n), 64'd112);
        chk("t2_aligned", 64'({aligned, fail}), 64'b10);
        chk("t2_p2", 64'(pulses[2] - snap[2]), 64'd3);
        chk("t2_p4", 64'(pulses[4] - snap[4]), 64'd5);
        chk("t2_p_other", 64'((pulses[0]-snap[0]) + (pulses[1]-snap[1]) + (pulses[3]-snap[3])), 64'd0);
        chk("t2_width", 64'(bad_width), 64'd0);
        chk("t2_spacing", 64'(bad_space), 64'd0);
`ifdef CAM_LVDS_ALIGN_SLIP_COUNT_EN
        chk("t2_slipcnt", 64'(slip_count), 64'h50300);
`else
        chk("t2_slipcnt", 64'(slip_count), 64'h0);
`endif

        // Lane 1 never sees the training word: exhausts 7 slips
        for (int i = 0; i < LANES; i++) k[i] = 0;
        fixed_en[1] = 1'b1;
        drive_rxd();
        take_snap();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!(aligned || fail) && n < 400) begin step(); n++; end
        chk("t3_latency", 64'(n), 64'd109);
        chk("t3_status", 64'({aligned, fail, busy}), 64'b010);
        chk("t3_lane_fail", 64'(lane_fail), 64'h02);
        chk("t3_lane_aligned", 64'(lane_aligned), 64'h1D);
        chk("t3_p1", 64'(pulses[1] - snap[1]), 64'd7);
        chk("t3_spacing", 64'({bad_width, bad_space}), 64'd0);
`ifdef CAM_LVDS_ALIGN_SLIP_COUNT_EN
        chk("t3_slipcnt", 64'(slip_count), 64'h00070);
`else
        chk("t3_slipcnt", 64'(slip_count), 64'h0);
`endif
        rx_locked = 1'b0;
        step();
        rx_locked = 1'b1;
        step();
        chk("t3_lock_ignored", 64'({fail, busy}), 64'b10);

        // Lock loss in DONE triggers an automatic retrain
        fixed_en[1] = 1'b0;
        k[1] = 0;
        drive_rxd();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!(aligned || fail) && n < 400) begin step(); n++; end
        chk("t4_first_align", 64'(n), 64'd82);
        rx_locked = 1'b0;
        step();
        chk("t4_drop", 64'({aligned, busy}), 64'b01);
        rx_locked = 1'b1;
        step();
        n = 1;
        while (!(aligned || fail) && n < 400) begin step(); n++; end
        chk("t4_relock_latency", 64'(n), 64'd81);
        chk("t4_aligned", 64'({aligned, fail, busy}), 64'b100);

        // Reset while lane 0 is settling after its first slip
        k[0] = 2;
        drive_rxd();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!bitslip[0] && n < 400) begin step(); n++; end
        chk("t5_first_slip", 64'(bitslip[0]), 64'd1);
        step();
        rst = 1'b1;
        step();
        chk("t5_rst_outputs", 64'({bitslip, busy, aligned, fail, lane_aligned, lane_fail}), 64'd0);
        chk("t5_rst_slipcnt", 64'(slip_count), 64'd0);
        rst = 1'b0;
        take_snap();
        repeat (30) step();
        chk("t5_no_pulses", 64'(pulses[0] - snap[0]), 64'd0);
        chk("t5_idle", 64'({busy, aligned, fail}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cam_lvds_align.md
Name: cam_lvds_align

Overview:
- Per-camera word-alignment controller for one `cam_lvds_rx` instance, which has 4 data lanes plus 1 sync lane, 8 bits each.
- Runs in the camera rx core-clock domain.
- Inputs: PLL lock and deserialized words. Output: the `rx_bitslip_ctrl` vector.
- Pulses each lane's bitslip until that lane shows the sensor training word, then reports aligned or fail status to software via PIO.
- One instance per camera, between `cam_lvds_rx` and the camera capture path in `top`.

Parameters:
- LANES, 5, lane count; lane LANES-1 is the sync lane.
- W, 8, bits per lane word.
- TRAIN_WORD, 8'h3A, training pattern after PCB inversion correction; must be rotation-aperiodic.
- MATCH_CYCLES, 16, consecutive matches required to declare a lane aligned.
- SETTLE_CYCLES, 4, cycles ignored after each bitslip pulse.
- LOCK_WAIT, 64, cycles rx_locked must stay high before training starts.

Ports:
- rxc  in  1  camera rx core clock (`cam_N_rxc`).
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle training request, already synchronized to rxc.
- rx_locked  in  1  LVDS PLL lock, already synchronized.
- rxd  in  LANES*W  deserialized words, polarity-corrected; lane i = rxd[i*W +: W].
- bitslip  out  LANES  drives rx_bitslip_ctrl; one-cycle pulses.
- busy  out  1  training in progress.
- aligned  out  1  all lanes aligned.
- fail  out  1  at least one lane exhausted its slips.
- lane_aligned  out  LANES  per-lane aligned status.
- lane_fail  out  LANES  per-lane fail status.
- slip_count  out  LANES*4  per-lane slip count (see Optional Feature).

Behaviour:
- Reset state: all outputs 0; top FSM = IDLE; all lanes = L_IDLE.
- Top FSM states: IDLE, WAIT_LOCK, TRAIN, DONE, FAIL. busy=1 in WAIT_LOCK and TRAIN.
- IDLE/DONE/FAIL, start=1: go to WAIT_LOCK next cycle. Lock counter cleared; all lane state cleared (lane_aligned, lane_fail, slip counts = 0; aligned/fail = 0).
- WAIT_LOCK: counter increments while rx_locked=1 and clears when rx_locked=0. On reaching LOCK_WAIT, go to TRAIN and issue a one-cycle lane_go to every lane.
- TRAIN: when every lane is in L_DONE or L_FAIL:
  - all lanes L_DONE: go to DONE, aligned=1.
  - otherwise: go to FAIL, fail=1.
  - aligned/fail are registered and rise on the cycle the state is entered.
- Loss of lock: rx_locked=0 in TRAIN or DONE sends the FSM back to WAIT_LOCK. Lanes are cleared, aligned drops the next cycle, and training reruns automatically. In FAIL, loss of lock is ignored.
- start while busy: ignored.
- Latency: with rx_locked already high and zero misalignment, aligned rises 1+LOCK_WAIT+MATCH_CYCLES+1 cycles after start (82 at defaults).
- Lane FSM states: L_IDLE, L_CHECK, L_SLIP, L_SETTLE, L_DONE, L_FAIL.
  - L_IDLE, lane_go: go to L_CHECK with match_cnt=0, slips=0.
  - L_CHECK, word==TRAIN_WORD: match_cnt++. On reaching MATCH_CYCLES, go to L_DONE and set lane_aligned.
  - L_CHECK, mismatch, slips==W-1: go to L_FAIL and set lane_fail.
  - L_CHECK, mismatch, slips<W-1: go to L_SLIP.
  - L_SLIP: bitslip[i]=1 for exactly this cycle; slips++; go to L_SETTLE.
  - L_SETTLE: data ignored for SETTLE_CYCLES cycles, then go to L_CHECK with match_cnt=0.
  - L_DONE/L_FAIL: hold until cleared.
- Minimum spacing between bitslip pulses on one lane: SETTLE_CYCLES+2 cycles.
- Lanes are independent and train in parallel; simultaneous pulses on different lanes are allowed.
- Lane clear has priority over every lane transition.
- rst mid-training: all state returns to reset values on the next edge, including any bitslip pulse in flight.

Optional Feature:
- Macro: CAM_LVDS_ALIGN_SLIP_COUNT_EN.
- Defined: slip_count[i*4 +: 4] shows that lane's registered slips value. It is cleared with the lane and holds its value in L_DONE/L_FAIL.
- Undefined: slip_count is tied to 0 and no extra registers are built.
- All other behaviour is identical either way.

Decomposition:
- Package `cam_lvds_align_pkg` holds:
  - top state enum: IDLE, WAIT_LOCK, TRAIN, DONE, FAIL.
  - lane state enum: L_IDLE, L_CHECK, L_SLIP, L_SETTLE, L_DONE, L_FAIL.
  - default constants: TRAIN_WORD, MATCH_CYCLES, SETTLE_CYCLES, LOCK_WAIT.
- One sub-module, `cam_lvds_lane_align`: per-lane FSM with match/settle/slip counters. It has inputs clear, go and word, and outputs bitslip, done, fail and slips. It is instantiated LANES times via generate.

Test Plan:
- Bench model: each lane's stream is TRAIN_WORD rotated by k bits; each bitslip pulse reduces k by 1 mod 8.
- All lanes k=0, locked high, start pulse: no bitslip pulses; aligned=1 exactly 82 cycles after start; lane_aligned=5'h1F; fail=0.
- Lane 2 k=3, sync lane k=5, others k=0: exactly 3 pulses on bitslip[2] and 5 on bitslip[4], each 1 cycle wide and spaced 6 cycles apart; aligned=1; slip_count lanes 2/4 = 3/5 (with macro).
- Lane 1 stream constant 8'h00: 7 pulses on bitslip[1], then lane_fail=5'h02 and fail=1 after the other lanes finish; aligned=0.
- rx_locked dropped for 1 cycle while in DONE: aligned=0 next cycle, busy=1; retrains and re-asserts aligned LOCK_WAIT+MATCH_CYCLES+1 cycles after lock returns.
- rst asserted while lane 0 is in L_SETTLE: all outputs 0 next cycle and no further bitslip pulses. start pulse during busy: no restart and slip sequence unchanged.
